// File: rtl/execute_writeback.sv
`default_nettype none
// ============================================================================
// Module   : execute_writeback
// Brief    : Execute stage. Single-cycle ALU with conditional writeback to
//            r0..r13, jumps via R14, overflow register R15 and {C,N,Z} flags.
//            Optional iterative MUL/DIV engine, enabled by the macro
//            EXECUTE_MULDIV_EN. Without it, opcodes 10/11 are illegal and
//            stall is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module execute_writeback #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] aval,
  input  logic [WIDTH-1:0] bval,
  output logic             stall,
  output logic             wr_en,
  output logic [3:0]       wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] overflow,
  output logic [2:0]       flags,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_target,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] c_OP_NOP = 5'd0;
  localparam logic [4:0] c_OP_MOV = 5'd1;
  localparam logic [4:0] c_OP_ADD = 5'd2;
  localparam logic [4:0] c_OP_SUB = 5'd3;
  localparam logic [4:0] c_OP_AND = 5'd4;
  localparam logic [4:0] c_OP_OR  = 5'd5;
  localparam logic [4:0] c_OP_XOR = 5'd6;
  localparam logic [4:0] c_OP_SHL = 5'd7;
  localparam logic [4:0] c_OP_SHR = 5'd8;
  localparam logic [4:0] c_OP_SRA = 5'd9;

  // Instruction fields
  logic [4:0]       w_opc;
  logic [3:0]       w_rc;
  logic [2:0]       w_cond;
  logic             w_cmp;
  logic             w_cond_ok;
  logic [SHW-1:0]   w_sh;

  assign w_opc  = instr[12:8];
  assign w_rc   = instr[7:4];
  assign w_cond = instr[3:1];
  assign w_cmp  = instr[0];
  assign w_sh   = bval[SHW-1:0];

  // Single-cycle ALU results
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_aux_en;
  logic [WIDTH-1:0] w_alu_aux;
  logic             w_alu_valid;
  logic             w_illegal_op;

  // Common commit bus (from ALU or from the finishing MUL/DIV)
  logic             w_commit;
  logic [WIDTH-1:0] w_cmt_res;
  logic [WIDTH-1:0] w_cmt_aux;
  logic             w_cmt_aux_en;
  logic             w_cmt_c;
  logic             w_cmt_cmp;
  logic [3:0]       w_cmt_rc;
  logic             w_ill;

  // Hooks to the multi-cycle engine
  logic             w_idle;
  logic             w_fin;
  logic [WIDTH-1:0] w_fin_res;
  logic [WIDTH-1:0] w_fin_aux;
  logic             w_fin_cmp;
  logic [3:0]       w_fin_rc;

  assign w_sum = {1'b0, aval} + {1'b0, bval};
  assign w_dif = {1'b0, aval} - {1'b0, bval};

  // Condition code evaluated against the current {C,N,Z} flags
  always_comb begin
    w_cond_ok = 1'b0;
    case (w_cond)
      3'd0:    w_cond_ok = 1'b1;
      3'd1:    w_cond_ok = flags[0];
      3'd2:    w_cond_ok = ~flags[0];
      3'd3:    w_cond_ok = flags[1];
      3'd4:    w_cond_ok = ~flags[1];
      3'd5:    w_cond_ok = flags[2];
      3'd6:    w_cond_ok = ~flags[2];
      default: w_cond_ok = 1'b0;
    endcase
  end

`ifdef EXECUTE_MULDIV_EN
  localparam logic [4:0] c_OP_MUL = 5'd10;
  localparam logic [4:0] c_OP_DIV = 5'd11;
  localparam int         CNTW     = $clog2(WIDTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mq;
  logic [WIDTH-1:0] r_opb;
  logic             r_is_div;
  logic             r_cmp;
  logic [3:0]       r_rc;
  logic             w_is_muldiv;
  logic             w_start;
  logic             w_last;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH+1:0] w_div_trial;
  logic [WIDTH-1:0] w_it_acc;
  logic [WIDTH-1:0] w_it_mq;
  logic             w_unused;

  assign w_unused  = ^{instr[31:13], w_div_trial[WIDTH]};
  assign w_idle    = (r_state == S_IDLE);
  assign w_start   = w_idle && w_cond_ok && w_is_muldiv;
  assign w_last    = (r_state == S_BUSY) && (r_cnt == CNTW'(WIDTH - 1));
  // Gated by rst so decode is released the instant reset asserts
  assign stall     = rst && ((r_state == S_BUSY) || w_start);

  assign w_fin     = w_last;
  assign w_fin_res = w_it_mq;
  assign w_fin_aux = w_it_acc;
  assign w_fin_cmp = r_cmp;
  assign w_fin_rc  = r_rc;

  // One shift-add (MUL) or restoring-subtract (DIV) step; acc holds the
  // product high word / remainder, mq holds the product low word / quotient
  always_comb begin
    w_mul_sum   = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_opb} : '0);
    w_div_shift = {r_acc, r_mq[WIDTH-1]};
    w_div_trial = {1'b0, w_div_shift} - {2'b00, r_opb};
    w_it_acc    = w_mul_sum[WIDTH:1];
    w_it_mq     = {w_mul_sum[0], r_mq[WIDTH-1:1]};
    if (r_is_div) begin
      if (!w_div_trial[WIDTH+1]) begin
        w_it_acc = w_div_trial[WIDTH-1:0];
        w_it_mq  = {r_mq[WIDTH-2:0], 1'b1};
      end else begin
        w_it_acc = w_div_shift[WIDTH-1:0];
        w_it_mq  = {r_mq[WIDTH-2:0], 1'b0};
      end
    end
  end

  // FSM next state: start on an accepted MUL/DIV, finish after WIDTH steps
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nx = S_BUSY;
      S_BUSY:  if (w_last)  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // FSM state register and iteration datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_cmp    <= 1'b0;
      r_rc     <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_start) begin
        r_cnt    <= '0;
        r_acc    <= '0;
        r_mq     <= aval;
        r_opb    <= bval;
        r_is_div <= (w_opc == c_OP_DIV);
        r_cmp    <= w_cmp;
        r_rc     <= w_rc;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_it_acc;
        r_mq  <= w_it_mq;
      end
    end
  end
`else
  logic w_unused;

  assign w_unused  = ^instr[31:13];
  assign w_idle    = 1'b1;
  assign stall     = 1'b0;
  assign w_fin     = 1'b0;
  assign w_fin_res = '0;
  assign w_fin_aux = '0;
  assign w_fin_cmp = 1'b0;
  assign w_fin_rc  = '0;
`endif

  // Opcode decode into a result, carry and optional implicit overflow value
  always_comb begin
    w_alu_res    = '0;
    w_alu_c      = 1'b0;
    w_alu_aux_en = 1'b0;
    w_alu_aux    = '0;
    w_alu_valid  = 1'b1;
    w_illegal_op = 1'b0;
`ifdef EXECUTE_MULDIV_EN
    w_is_muldiv  = 1'b0;
`endif
    case (w_opc)
      c_OP_NOP: w_alu_valid = 1'b0;
      c_OP_MOV: w_alu_res = bval;
      c_OP_ADD: begin
        w_alu_res    = w_sum[WIDTH-1:0];
        w_alu_c      = w_sum[WIDTH];
        w_alu_aux_en = 1'b1;
        w_alu_aux    = WIDTH'(w_sum[WIDTH]);
      end
      c_OP_SUB: begin
        w_alu_res    = w_dif[WIDTH-1:0];
        w_alu_c      = w_dif[WIDTH];
        w_alu_aux_en = 1'b1;
        w_alu_aux    = WIDTH'(w_dif[WIDTH]);
      end
      c_OP_AND: w_alu_res = aval & bval;
      c_OP_OR:  w_alu_res = aval | bval;
      c_OP_XOR: w_alu_res = aval ^ bval;
      c_OP_SHL: w_alu_res = aval << w_sh;
      c_OP_SHR: w_alu_res = aval >> w_sh;
      c_OP_SRA: w_alu_res = $signed(aval) >>> w_sh;
`ifdef EXECUTE_MULDIV_EN
      c_OP_MUL, c_OP_DIV: begin
        w_alu_valid = 1'b0;
        w_is_muldiv = 1'b1;
      end
`endif
      default: begin
        w_alu_valid  = 1'b0;
        w_illegal_op = 1'b1;
      end
    endcase
  end

  // Select what retires this cycle: a finishing MUL/DIV has priority, and
  // new instructions are only looked at while idle
  always_comb begin
    w_commit     = 1'b0;
    w_cmt_res    = '0;
    w_cmt_aux    = '0;
    w_cmt_aux_en = 1'b0;
    w_cmt_c      = 1'b0;
    w_cmt_cmp    = 1'b0;
    w_cmt_rc     = '0;
    w_ill        = 1'b0;
    if (w_fin) begin
      w_commit     = 1'b1;
      w_cmt_res    = w_fin_res;
      w_cmt_aux    = w_fin_aux;
      w_cmt_aux_en = 1'b1;
      w_cmt_cmp    = w_fin_cmp;
      w_cmt_rc     = w_fin_rc;
    end else if (w_idle) begin
      w_ill = w_illegal_op;
      if (w_cond_ok && w_alu_valid) begin
        w_commit     = 1'b1;
        w_cmt_res    = w_alu_res;
        w_cmt_aux    = w_alu_aux;
        w_cmt_aux_en = w_alu_aux_en;
        w_cmt_c      = w_alu_c;
        w_cmt_cmp    = w_cmp;
        w_cmt_rc     = w_rc;
      end
    end
  end

  // Registered strobes (single-cycle pulses), flags and R15
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      pc_load   <= 1'b0;
      pc_target <= '0;
      illegal   <= 1'b0;
      overflow  <= '0;
      flags     <= '0;
    end else begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      pc_load   <= 1'b0;
      pc_target <= '0;
      illegal   <= w_ill;
      if (w_commit) begin
        if (w_cmt_cmp) begin
          flags <= {w_cmt_c, w_cmt_res[WIDTH-1], (w_cmt_res == '0)};
        end else begin
          if (w_cmt_rc == 4'd15) begin
            overflow <= w_cmt_res;
          end else begin
            if (w_cmt_aux_en) overflow <= w_cmt_aux;
            if (w_cmt_rc == 4'd14) begin
              pc_load   <= 1'b1;
              pc_target <= w_cmt_res;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= w_cmt_rc;
              wr_data <= w_cmt_res;
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_writeback
// Brief    : Self-checking bench for execute_writeback. Directed steps plus a
//            randomized run compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_writeback;

  localparam int W = 32;

`ifdef EXECUTE_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  instr;
  logic [W-1:0] aval;
  logic [W-1:0] bval;
  logic         stall;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic [W-1:0] overflow;
  logic [2:0]   flags;
  logic         pc_load;
  logic [W-1:0] pc_target;
  logic         illegal;

  execute_writeback #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .aval      (aval),
    .bval      (bval),
    .stall     (stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .overflow  (overflow),
    .flags     (flags),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model architectural state and expected strobes
  logic [2:0]   m_flags;
  logic [W-1:0] m_ovf;
  logic         e_wr_en;
  logic [3:0]   e_wr_addr;
  logic [W-1:0] e_wr_data;
  logic         e_pc_load;
  logic [W-1:0] e_pc_target;
  logic         e_illegal;
  logic         e_multi;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int opc, input int rc, input int cond, input int cmp);
    logic [31:0] v;
    v = '0;
    v[12:8] = opc[4:0];
    v[7:4]  = rc[3:0];
    v[3:1]  = cond[2:0];
    v[0]    = cmp[0];
    return v;
  endfunction

  // Architectural model: what the instruction should do, in plain arithmetic
  task automatic model(input logic [31:0] ins, input logic [W-1:0] a, input logic [W-1:0] b);
    int opc, rc, cond;
    bit cmp, ok, legal, has_aux;
    logic [W:0]   s;
    logic [63:0]  p;
    logic [W-1:0] res, aux;
    logic         c;
    opc  = int'(ins[12:8]);
    rc   = int'(ins[7:4]);
    cond = int'(ins[3:1]);
    cmp  = ins[0];
    e_wr_en = 0; e_wr_addr = 0; e_wr_data = 0;
    e_pc_load = 0; e_pc_target = 0; e_multi = 0;
    case (cond)
      0: ok = 1;
      1: ok = m_flags[0];
      2: ok = !m_flags[0];
      3: ok = m_flags[1];
      4: ok = !m_flags[1];
      5: ok = m_flags[2];
      6: ok = !m_flags[2];
      default: ok = 0;
    endcase
    legal = (opc <= 9) || (MULDIV && (opc == 10 || opc == 11));
    e_illegal = !legal;
    if (!(ok && legal && opc != 0)) return;
    res = 0; aux = 0; c = 0; has_aux = 0;
    case (opc)
      1: res = b;
      2: begin s = {1'b0, a} + {1'b0, b}; res = s[W-1:0]; c = s[W]; aux = W'(c); has_aux = 1; end
      3: begin res = a - b; c = (a < b); aux = W'(c); has_aux = 1; end
      4: res = a & b;
      5: res = a | b;
      6: res = a ^ b;
      7: res = a << b[4:0];
      8: res = a >> b[4:0];
      9: res = W'($signed(a) >>> b[4:0]);
      10: begin p = 64'(a) * 64'(b); res = p[31:0]; aux = p[63:32]; has_aux = 1; e_multi = 1; end
      11: begin
        if (b == 0) begin res = '1; aux = a; end
        else begin res = a / b; aux = a % b; end
        has_aux = 1; e_multi = 1;
      end
      default: ;
    endcase
    if (cmp) begin
      m_flags = {c, res[W-1], (res == 0)};
    end else begin
      if (rc < 14) begin e_wr_en = 1; e_wr_addr = rc[3:0]; e_wr_data = res; end
      else if (rc == 14) begin e_pc_load = 1; e_pc_target = res; end
      if (rc == 15) m_ovf = res;
      else if (has_aux) m_ovf = aux;
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".wr_en"},     wr_en,     e_wr_en);
    chk({tag, ".wr_addr"},   wr_addr,   e_wr_addr);
    chk({tag, ".wr_data"},   wr_data,   e_wr_data);
    chk({tag, ".pc_load"},   pc_load,   e_pc_load);
    chk({tag, ".pc_target"}, pc_target, e_pc_target);
    chk({tag, ".illegal"},   illegal,   e_illegal);
    chk({tag, ".overflow"},  overflow,  m_ovf);
    chk({tag, ".flags"},     flags,     m_flags);
  endtask

  // Present one instruction, wait out its latency, check the retirement
  task automatic issue(input string tag, input logic [31:0] ins, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    @(negedge clk);
    instr = ins; aval = a; bval = b;
    model(ins, a, b);
    #1;
    chk({tag, ".stall_c0"}, stall, e_multi);
    if (e_multi) begin
      n = 1;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk); #1;
        if (!stall) break;
        n++;
        instr = '0;
      end
      chk({tag, ".stall_cycles"}, n, W + 1);
    end else begin
      @(posedge clk); #1;
    end
    instr = '0;
    chk_outs(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int opc, rc, cond, cmp, wr_seen, st_seen;
    logic [W-1:0] ra, rb;
    rst = 1'b0; instr = '0; aval = '0; bval = '0;
    m_flags = '0; m_ovf = '0;
    e_wr_en = 0; e_wr_addr = 0; e_wr_data = 0; e_pc_load = 0;
    e_pc_target = 0; e_illegal = 0; e_multi = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset.stall", stall, 1'b0);
    chk_outs("reset");
    @(negedge clk); rst = 1'b1;

    issue("add_carry", mk(2, 3, 0, 0), 32'hFFFF_FFFF, 32'd2);
    issue("sub_cmp",   mk(3, 0, 0, 1), 32'd5, 32'd5);
    issue("mov_z",     mk(1, 2, 1, 0), 32'd0, 32'd7);
    issue("mov_nz",    mk(1, 2, 2, 0), 32'd0, 32'd7);
    issue("mul",       mk(10, 4, 0, 0), 32'h0001_0000, 32'h0003_0000);
    issue("div",       mk(11, 5, 0, 0), 32'd100, 32'd7);
    issue("jump",      mk(1, 14, 0, 0), 32'd0, 32'h40);
    issue("mov_r15",   mk(1, 15, 0, 0), 32'd0, 32'd9);
    issue("illegal20", mk(20, 6, 0, 0), 32'd1, 32'd2);
    @(posedge clk); #1;
    chk("illegal20.pulse_end", illegal, 1'b0);
    issue("div0",      mk(11, 7, 0, 0), 32'd5, 32'd0);
    issue("bubble",    32'h0, 32'h1234_5678, 32'h9ABC_DEF0);
    issue("mul_cmp",   mk(10, 1, 0, 1), 32'hFFFF_FFFF, 32'd1);
    issue("sra",       mk(9, 8, 0, 0), 32'h8000_0010, 32'd4);

    for (int k = 0; k < 60; k++) begin
      opc  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 31)) : int'($urandom_range(0, 11));
      rc   = int'($urandom_range(0, 15));
      cond = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : 0;
      cmp  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      ra   = $urandom;
      rb   = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
      issue($sformatf("rand%0d", k), mk(opc, rc, cond, cmp), ra, rb);
    end

    // Reset while a MUL is in flight
    issue("pre_rst", mk(1, 15, 0, 0), 32'd0, 32'd77);
    @(negedge clk);
    instr = mk(10, 3, 0, 0); aval = 32'h1234; bval = 32'h5678;
    @(posedge clk); #1;
    instr = '0;
    repeat (9) @(posedge clk);
    #1;
    chk("rst_mid.busy", stall, MULDIV);
    @(negedge clk); rst = 1'b0;
    #1;
    m_flags = '0; m_ovf = '0;
    chk("rst_mid.stall", stall, 1'b0);
    chk("rst_mid.overflow", overflow, m_ovf);
    chk("rst_mid.flags", flags, m_flags);
    chk("rst_mid.wr_en", wr_en, 1'b0);
    @(negedge clk); rst = 1'b1;
    wr_seen = 0; st_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      wr_seen = wr_seen | int'(wr_en) | int'(pc_load);
      st_seen = st_seen | int'(stall);
    end
    chk("rst_mid.no_wb", wr_seen, 0);
    chk("rst_mid.no_stall", st_seen, 0);
    chk("rst_mid.overflow_after", overflow, m_ovf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
